// File: rtl/decrementa_serial.sv
// rtl/decrementa_serial.sv - bit-serial decrement unit with start/busy/done handshake
module decrementa_serial #(
  parameter int         WIDTH  = 4,
  parameter logic [1:0] OP_DEC = 2'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flag,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] O,
  output logic             Bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opr;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_o;
  logic             r_bo;

  logic [WIDTH-1:0] w_operand;
  logic             w_is_dec;
  logic             w_r;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  assign w_operand    = flag ? B : A;
  assign w_is_dec     = (select == OP_DEC);
  assign w_r          = r_opr[0] ^ r_borrow;
  assign w_borrow_nxt = ~r_opr[0] & r_borrow;
  assign w_res_nxt    = {w_r, r_res[WIDTH-1:1]};
  assign w_last       = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_is_dec ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts the LSB-first result is aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opr    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_o      <= '0;
      r_bo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_dec) begin
              r_opr    <= w_operand;
              r_borrow <= 1'b1;
              r_cnt    <= '0;
              r_res    <= '0;
            end else begin
              r_o  <= w_operand;
              r_bo <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          r_res    <= w_res_nxt;
          r_opr    <= r_opr >> 1;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_o  <= w_res_nxt;
            r_bo <= w_borrow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign O  = r_o;
  assign Bo = r_bo;

endmodule

// File: tb/tb_decrementa_serial.sv
// tb/tb_decrementa_serial.sv - directed scoreboard bench for decrementa_serial
module tb_decrementa_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         flag;
  logic [1:0]   select;
  logic [W-1:0] O;
  logic         Bo;
  logic         busy;
  logic         done;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [W:0] sb[$];

  decrementa_serial #(.WIDTH(W), .OP_DEC(2'd3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .flag(flag),
    .select(select), .O(O), .Bo(Bo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(posedge clk) begin
    logic [W:0] e;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL unexpected_done: observed O=%0h Bo=%0b expected no done", O, Bo);
      end else begin
        e = sb.pop_front();
        chk("sb_O", 32'(O), 32'(e[W-1:0]));
        chk("sb_Bo", 32'(Bo), 32'(e[W]));
      end
    end
  end

  task automatic launch(input logic f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] sel);
    logic [W-1:0] opd;
    opd = f ? b : a;
    if (sel == 2'd3) sb.push_back({(opd == '0), opd - W'(1)});
    else             sb.push_back({1'b0, opd});
    A = a; B = b; flag = f; select = sel; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); flag = 1'($urandom); select = 2'($urandom);
  endtask

  task automatic run_op(input string tag, input logic f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] sel);
    int lat;
    int nb;
    logic [W-1:0] opd;
    logic [W-1:0] eo;
    logic         ebo;
    opd = f ? b : a;
    eo  = (sel == 2'd3) ? opd - W'(1) : opd;
    ebo = (sel == 2'd3) && (opd == '0);
    launch(f, a, b, sel);
    lat = 1;
    nb  = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) nb++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, (sel == 2'd3) ? W + 1 : 1);
    chk({tag, "_busy_cycles"}, nb, (sel == 2'd3) ? W : 0);
    chk({tag, "_busy_in_done"}, 32'(busy), 0);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done), 0);
    chk({tag, "_O_held"}, 32'(O), 32'(eo));
    chk({tag, "_Bo_held"}, 32'(Bo), 32'(ebo));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; flag = 1'b0; select = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_O", 32'(O), 0);
    chk("rst_Bo", 32'(Bo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    run_op("dec_5", 1'b0, 4'b0101, 4'b1100, 2'd3);
    run_op("dec_B0_wrap", 1'b1, 4'b1111, 4'b0000, 2'd3);
    run_op("dec_8_ripple", 1'b0, 4'b1000, 4'b0011, 2'd3);
    run_op("pass_A", 1'b0, 4'b1010, 4'b0001, 2'd2);
    run_op("pass_B", 1'b1, 4'b0110, 4'b1001, 2'd0);

    // Starts during SHIFT and DONE must be dropped.
    launch(1'b0, 4'b0011, 4'b0000, 2'd3);
    A = 4'b1111; select = 2'd3; flag = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    chk("ign_done_seen", 32'(done), 1);
    chk("ign_O", 32'(O), 32'(4'b0010));
    A = 4'b1111; select = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_idle_busy", 32'(busy), 0);
    chk("ign_idle_done", 32'(done), 0);
    run_op("after_ign", 1'b0, 4'b1001, 4'b0000, 2'd3);

    // Reset during the second SHIFT cycle aborts without a done pulse.
    A = 4'b0110; flag = 1'b0; select = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_O", 32'(O), 0);
    chk("abort_Bo", 32'(Bo), 0);
    for (int i = 0; i < W + 2; i++) tick();
    run_op("dec_1", 1'b0, 4'b0001, 4'b1111, 2'd3);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rand_dec", 1'($urandom), ra, rb, 2'd3);
    end

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decrementa_serial.md
Name: decrementa_serial

Overview:
- Bit-serial decrement unit; the counterpart of the ALU's increment slice.
- Selects operand A or B by `flag`, then subtracts 1, LSB first, one bit per clock, using a borrow flip-flop.
- Has a start/busy/done handshake so the ALU control FSM can launch an operation and wait for the result.
- When `select` is not the decrement opcode, the operand passes through unchanged.

Parameters:
- WIDTH, 4, operand/result width in bits (legal ≥ 2).
- OP_DEC, 2'd3, `select` code that requests a decrement.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand 0.
- B  input  WIDTH  operand 1.
- flag  input  1  operand select: 0 = A, 1 = B; sampled with start.
- select  input  2  operation code; sampled with start.
- O  output  WIDTH  result register; held until next accepted start.
- Bo  output  1  borrow out: 1 when the decremented operand was 0 (wrap to all ones).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when O/Bo are valid.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, O=0, Bo=0, busy=0, done=0, shift/count/borrow regs cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=0: stay.
  - start=1 and select==OP_DEC: opr ← (flag ? B : A), borrow ← 1, cnt ← 0, res ← 0; go to SHIFT.
  - start=1 and select!=OP_DEC: O ← (flag ? B : A), Bo ← 0; go to DONE (pass-through).
- SHIFT, each edge:
  - r = opr[0] XOR borrow.
  - borrow ← (NOT opr[0]) AND borrow.
  - res ← {r, res[WIDTH-1:1]}; opr ← opr >> 1; cnt ← cnt+1.
  - On the edge where cnt==WIDTH-1: O ← {r, res[WIDTH-1:1]}, Bo ← (NOT opr[0]) AND borrow; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE on the next edge.
- busy=1 only in SHIFT; done=1 only in DONE; the two are never high together.
- Latency, counted from the edge that samples start:
  - Decrement: done is high in the cycle after edge WIDTH (WIDTH SHIFT cycles), i.e. WIDTH+1 cycles from the start cycle to the done cycle.
  - Pass-through: done is high in the cycle after edge 0.
- start is ignored in SHIFT and DONE; it is not queued. Back-to-back requests therefore need at least one IDLE cycle, so the minimum decrement issue interval is WIDTH+2 cycles.
- A, B, flag and select may change freely after the start edge; the captured values are used.
- O and Bo change only on the transition into DONE (or on reset); they are stable between operations.
- Arithmetic is modulo 2^WIDTH: operand 0 gives O = all ones with Bo=1; every other operand gives O = operand−1 with Bo=0.
- Fixed latency: no early termination when the borrow clears.

Test Plan:
- Reset, then flag=0, A=4'b0101, select=3, start for 1 cycle -> busy high 4 cycles, then done pulse with O=4'b0100, Bo=0.
- flag=1, B=4'b0000, A=4'b1111, select=3, start -> O=4'b1111, Bo=1 after 4 SHIFT cycles (B selected, wrap).
- A=4'b1000, select=3, flag=0 -> O=4'b0111, Bo=0 (borrow ripples through 3 zero bits).
- A=4'b1010, select=2, flag=0, start -> no busy; done pulse in the cycle after the start edge with O=4'b1010, Bo=0.
- Decrement of A=4'b0011 launched; start pulsed again with A=4'b1111 during SHIFT and again during DONE -> both ignored, single done with O=4'b0010; a new start in the following IDLE cycle is accepted.
- Decrement of A=4'b0110 launched, rst=1 on the 2nd SHIFT cycle -> next cycle busy=0, done=0, O=0, Bo=0; no done pulse; a fresh decrement of 4'b0001 then yields O=4'b0000, Bo=0.
